// File: rtl/sha_mem_responder.sv
// Word-memory responder for the SHA-256 engine: loads a host message, kicks the engine,
// serves its 1-cycle reads, captures the 8-word digest and streams it back to the host.
module sha_mem_responder #(
  parameter int          DEPTH       = 64,
  parameter logic [15:0] MSG_BASE    = 16'd0,
  parameter int          MSG_WORDS   = 20,
  parameter logic [15:0] OUT_BASE    = 16'd32,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              eng_start,
  input  logic              eng_done,
  output logic [15:0]       message_addr,
  output logic [15:0]       output_addr,
  input  logic [15:0]       mem_addr,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              err_len,
  output logic              err_timeout,
  input  logic              err_clr
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [15:0] DEPTH_A = 16'(DEPTH);
  localparam logic [15:0] LAST_W  = 16'(MSG_WORDS - 1);
  localparam logic [TW-1:0] TO_LIM = TW'(TIMEOUT_CYC);

  if ((int'(MSG_BASE) + MSG_WORDS > DEPTH) || (int'(OUT_BASE) + 8 > DEPTH)) begin : g_bad_cfg
    $error("sha_mem_responder: message or digest window exceeds DEPTH");
  end

  typedef enum logic [2:0] {S_LOAD, S_KICK, S_WAIT_LO, S_WAIT_HI, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] arr [DEPTH];
  logic [DATA_W-1:0] cap [8];
  logic [15:0]       wcnt;
  logic [TW-1:0]     tcnt;
  logic [2:0]        rcnt;

  logic in_acc, load_end, len_bad, waiting, timeout_hit, out_hs;
  logic eng_wr, cap_hit;
  logic [DATA_W-1:0] cap_first;

  assign message_addr = MSG_BASE;
  assign output_addr  = OUT_BASE;
  assign in_ready     = (state == S_LOAD);

  assign in_acc      = in_ready && in_valid;
  assign load_end    = in_acc && (in_last || (wcnt == LAST_W));
  assign len_bad     = in_acc && in_last && (wcnt != LAST_W);
  assign waiting     = (state == S_WAIT_LO) || (state == S_WAIT_HI);
  assign timeout_hit = waiting && (tcnt == TO_LIM);
  assign out_hs      = (state == S_DRAIN) && out_valid && out_ready;
  assign eng_wr      = mem_we && (mem_addr < DEPTH_A) && (state != S_LOAD);
  assign cap_hit     = eng_wr && (mem_addr >= OUT_BASE) && (mem_addr < OUT_BASE + 16'd8);
  // A digest write landing on the DRAIN-entry edge must still reach the first output word.
  assign cap_first   = (cap_hit && (mem_addr == OUT_BASE)) ? mem_write_data : cap[0];

  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:    if (load_end) state_nxt = S_KICK;
      S_KICK:    state_nxt = S_WAIT_LO;
      S_WAIT_LO: if (timeout_hit) state_nxt = S_LOAD;
                 else if (!eng_done) state_nxt = S_WAIT_HI;
      S_WAIT_HI: if (timeout_hit) state_nxt = S_LOAD;
                 else if (eng_done) state_nxt = S_DRAIN;
      S_DRAIN:   if (out_hs && (rcnt == 3'd7)) state_nxt = S_LOAD;
      default:   state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_LOAD;
      wcnt        <= '0;
      tcnt        <= '0;
      eng_start   <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state     <= state_nxt;
      eng_start <= (state_nxt == S_KICK);
      if (load_end)    wcnt <= '0;
      else if (in_acc) wcnt <= wcnt + 16'd1;
      if (state == S_KICK) tcnt <= '0;
      else if (waiting)    tcnt <= tcnt + 1'b1;
      // Clear wins over a same-cycle set; a persisting condition re-sets next cycle.
      err_len     <= err_clr ? 1'b0 : (err_len | len_bad);
      err_timeout <= err_clr ? 1'b0 : (err_timeout | timeout_hit);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      rcnt      <= '0;
    end else if ((state == S_WAIT_HI) && (state_nxt == S_DRAIN)) begin
      out_valid <= 1'b1;
      out_data  <= cap_first;
      out_last  <= 1'b0;
      rcnt      <= '0;
    end else if (out_hs) begin
      if (rcnt == 3'd7) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end else begin
        rcnt     <= rcnt + 3'd1;
        out_data <= cap[rcnt + 3'd1];
        out_last <= (rcnt == 3'd6);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) cap[i] <= '0;
    end else if (state == S_LOAD) begin
      for (int i = 0; i < 8; i++) cap[i] <= '0;
    end else if (cap_hit) begin
      cap[3'(mem_addr - OUT_BASE)] <= mem_write_data;
    end
  end

  // Host and engine write ports are mutually exclusive by state.
  always_ff @(posedge clk) begin
    if (in_acc)      arr[AW'(MSG_BASE + wcnt)] <= in_data;
    else if (eng_wr) arr[AW'(mem_addr)]        <= mem_write_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_read_data <= '0;
    else          mem_read_data <= (mem_addr < DEPTH_A) ? arr[AW'(mem_addr)] : '0;
  end

endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
- Memory-side responder for the SHA-256 engine's word memory interface (mem_addr / mem_we / mem_write_data / mem_read_data, 1-cycle read latency).
- Loads a message from a host stream into a local word array and issues the engine start pulse.
- Serves the engine's reads, captures its 8-word digest write burst, then streams the digest back to the host.
- Sits between the host/test harness and the engine, replacing a generic SRAM.

Parameters:
DEPTH, 64, words in local array (address range 0..DEPTH-1)
MSG_BASE, 16'd0, array address of message word 0; driven on message_addr
MSG_WORDS, 20, message words per job (640-bit header)
OUT_BASE, 16'd32, array address of digest word 0; driven on output_addr
TIMEOUT_CYC, 1024, max cycles waiting on engine before abort

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  host message word valid
in_ready  out  1  high only in LOAD
in_data  in  32  host message word
in_last  in  1  host marks final word
eng_start  out  1  1-cycle start pulse to engine
eng_done  in  1  engine done (high when idle)
message_addr  out  16  constant MSG_BASE
output_addr  out  16  constant OUT_BASE
mem_addr  in  16  engine word address
mem_we  in  1  engine write enable
mem_write_data  in  32  engine write data
mem_read_data  out  32  registered read data
out_valid  out  1  digest word valid
out_ready  in  1  host accepts digest word
out_data  out  32  digest word
out_last  out  1  high with digest word 7
err_len  out  1  sticky: in_last on word != MSG_WORDS-1
err_timeout  out  1  sticky: engine timeout
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (async): state=LOAD; counters=0; eng_start=0; mem_read_data=0; out_valid=0; out_data=0; out_last=0; err_* =0; capture regs=0. Array contents not reset. in_ready=1 while in LOAD.
- Read port, every cycle regardless of state: mem_read_data <= (mem_addr<DEPTH) ? arr[mem_addr] : 0.
  - Latency exactly 1 cycle.
  - Read-during-write to the same address returns the old data.
- Engine write: if mem_we and mem_addr<DEPTH and state != LOAD -> arr[mem_addr] <= mem_write_data. Out-of-range writes are dropped.
  - If OUT_BASE <= mem_addr < OUT_BASE+8, also cap[mem_addr-OUT_BASE] <= mem_write_data.
  - Repeated writes to the same slot: last one wins.
- FSM: LOAD -> KICK -> WAIT_LO -> WAIT_HI -> DRAIN -> LOAD.
  - LOAD: each in_valid&in_ready writes arr[MSG_BASE+wcnt] <= in_data; wcnt++.
    - Leave to KICK after the word with wcnt==MSG_WORDS-1, or on in_last (whichever first).
    - in_last with wcnt != MSG_WORDS-1 -> err_len=1; unloaded words keep prior contents.
    - Clear cap[0..7]; tcnt=0.
  - KICK: eng_start=1 for exactly one cycle -> WAIT_LO.
  - WAIT_LO: wait for eng_done==0 -> WAIT_HI.
  - WAIT_HI: wait for eng_done==1 -> DRAIN; the following cycle out_valid=1, out_data=cap[0].
  - Timeout: tcnt increments each cycle in WAIT_LO/WAIT_HI, reset to 0 in KICK. When tcnt==TIMEOUT_CYC -> err_timeout=1, state=LOAD, no drain.
  - DRAIN: present cap[rcnt]; hold out_data stable while out_valid & !out_ready.
    - On handshake rcnt++; out_last = (rcnt==7).
    - Handshake on word 7 -> out_valid=0, state=LOAD, wcnt=0.
- err_clr has priority over a same-cycle error set: error bits read 0 that cycle and are set next cycle if the condition persists.
- eng_start is never reasserted before DRAIN completes or timeout.
- Host words presented outside LOAD are not accepted (in_ready=0) and not lost; the host holds them.
- Reset mid-operation (any state) returns to LOAD immediately. No partial digest is emitted.
- Address arithmetic is 16-bit unsigned; MSG_BASE+MSG_WORDS and OUT_BASE+8 must be <= DEPTH (elaboration-time assertion).

Test Plan:
- Load words 32'h1000_0000+i (i=0..19) with in_last on i=19, then drive mem_addr=5 -> mem_read_data=32'h1000_0005 on the next cycle; mem_addr=16'h0100 -> 0; err_len=0.
- Engine model: after eng_start, drops eng_done for 100 cycles, writes 32'hA0..A7 to addresses 32..39 with mem_we, raises eng_done -> exactly one eng_start pulse, then digest A0..A7 in order with out_last only on A7.
- Drain with out_ready low for 3 cycles on word 2 -> out_data holds 32'hA2 with out_valid high; no word skipped or duplicated.
- in_last on word 4 -> err_len=1, KICK next cycle; err_clr pulse -> err_len=0.
- Engine holds eng_done=1 forever -> err_timeout=1 after 1024 wait cycles, state LOAD, in_ready=1, out_valid never asserted.
- reset_n low mid-DRAIN after word 3 -> out_valid=0 immediately; the next job completes normally with a fresh digest.
